// File: rtl/demux_pkg.sv
// Shared widths and slot state encoding for the 1-to-2 result demultiplexer.
package demux_pkg;

  localparam int DEMUX_WIDTH = 32;
  localparam int DEMUX_CW    = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux_1to2_reg_out_slot.sv
// One-entry registered output slot: data register, EMPTY/FULL state machine
// and a wrapping count of completed valid/ready handshakes.
module out_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int CW    = DEMUX_CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CW-1:0]    count
);

  slot_state_t      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    count_q, count_d;
  logic             drain;

  assign drain = valid & ready;

  // Reset drops any held word without counting it as delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (load) state_d = SLOT_FULL;
      SLOT_FULL:  if (drain && !load) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  // Load is only issued when the slot is empty or draining, so a held word
  // is never overwritten before it has been delivered.
  always_comb begin
    data_d  = load ? din : data_q;
    count_d = count_q + {{(CW-1){1'b0}}, drain};
  end

  always_comb begin
    valid = (state_q == SLOT_FULL);
    dout  = data_q;
    count = count_q;
  end

endmodule

// File: rtl/demux_1to2_reg.sv
// Steers the ALU result word to the write-back slot (X) or the store/forward
// slot (Y); each slot has its own handshake so one stalled side never blocks the other.
module demux_1to2_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int CW    = DEMUX_CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] R,
  input  logic             C,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] X,
  output logic             x_valid,
  input  logic             x_ready,
  output logic [WIDTH-1:0] Y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [CW-1:0]    x_count,
  output logic [CW-1:0]    y_count
);

  logic accept;
  logic loadX;
  logic loadY;

  // Readiness depends only on the slot currently selected by C.
  always_comb begin
    in_ready = C ? (~y_valid | y_ready) : (~x_valid | x_ready);
    accept   = in_valid & in_ready;
    loadX    = accept & ~C;
    loadY    = accept &  C;
  end

  out_slot #(.WIDTH(WIDTH), .CW(CW)) slotX (
    .clk   (clk),
    .rst   (rst),
    .load  (loadX),
    .din   (R),
    .ready (x_ready),
    .dout  (X),
    .valid (x_valid),
    .count (x_count)
  );

  out_slot #(.WIDTH(WIDTH), .CW(CW)) slotY (
    .clk   (clk),
    .rst   (rst),
    .load  (loadY),
    .din   (R),
    .ready (y_ready),
    .dout  (Y),
    .valid (y_valid),
    .count (y_count)
  );

endmodule

// File: tb/tb_demux_1to2_reg.sv
// Self-checking bench for demux_1to2_reg: directed scenarios plus random
// traffic, checked by a queue-based scoreboard fed from a per-destination model.
module tb_demux_1to2_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] R;
  logic        C;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] X;
  logic        x_valid;
  logic        x_ready;
  logic [31:0] Y;
  logic        y_valid;
  logic        y_ready;
  logic [7:0]  x_count;
  logic [7:0]  y_count;

  int checkCount = 0;
  int failCount  = 0;

  // Reference model: each destination is a capacity-one buffer plus a delivery tally.
  logic [31:0] xq[$];
  logic [31:0] yq[$];
  bit          xFull = 0;
  bit          yFull = 0;
  logic [7:0]  xCnt = '0;
  logic [7:0]  yCnt = '0;

  bit          pubXValid = 0;
  bit          pubYValid = 0;
  bit          pubInReady = 0;
  logic [7:0]  pubXCount = '0;
  logic [7:0]  pubYCount = '0;
  bit          monitorOn = 0;

  demux_1to2_reg dut (
    .clk      (clk),
    .rst      (rst),
    .R        (R),
    .C        (C),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .X        (X),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .Y        (Y),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .x_count  (x_count),
    .y_count  (y_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs, advances the model, and returns #1 after the edge.
  task automatic applyStimulus(input bit rstIn, input bit iv, input logic [31:0] r,
                               input bit c, input bit xr, input bit yr);
    bit expReady;
    bit accept;
    rst      = rstIn;
    in_valid = iv;
    R        = r;
    C        = c;
    x_ready  = xr;
    y_ready  = yr;
    expReady   = c ? (!yFull || yr) : (!xFull || xr);
    accept     = iv && expReady;
    pubXValid  = xFull;
    pubYValid  = yFull;
    pubInReady = expReady;
    pubXCount  = xCnt;
    pubYCount  = yCnt;
    if (rstIn) begin
      xFull = 0;
      yFull = 0;
      xCnt  = '0;
      yCnt  = '0;
    end else begin
      if (xFull && xr) xCnt = xCnt + 8'd1;
      if (yFull && yr) yCnt = yCnt + 8'd1;
      xFull = (xFull && !xr) || (accept && !c);
      yFull = (yFull && !yr) || (accept && c);
      if (accept && !c) xq.push_back(r);
      if (accept && c)  yq.push_back(r);
    end
    @(posedge clk);
    #1;
    if (rstIn) begin
      xq.delete();
      yq.delete();
    end
  endtask

  // Monitor: checks handshake outputs and pops a word on every delivery.
  always @(negedge clk) begin
    if (monitorOn) begin
      checkOutput("in_ready", {31'b0, in_ready}, {31'b0, pubInReady});
      checkOutput("x_valid", {31'b0, x_valid}, {31'b0, pubXValid});
      checkOutput("y_valid", {31'b0, y_valid}, {31'b0, pubYValid});
      checkOutput("x_count", {24'b0, x_count}, {24'b0, pubXCount});
      checkOutput("y_count", {24'b0, y_count}, {24'b0, pubYCount});
      if (x_valid) begin
        checkOutput("x_pending", {31'b0, xq.size() != 0}, 32'd1);
        if (xq.size() != 0) begin
          checkOutput("X_data", X, xq[0]);
          if (x_ready) void'(xq.pop_front());
        end
      end
      if (y_valid) begin
        checkOutput("y_pending", {31'b0, yq.size() != 0}, 32'd1);
        if (yq.size() != 0) begin
          checkOutput("Y_data", Y, yq[0]);
          if (y_ready) void'(yq.pop_front());
        end
      end
    end
  end

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    monitorOn = 1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("idle_X", X, 32'd0);
      checkOutput("idle_Y", Y, 32'd0);
    end

    applyStimulus(0, 1, 32'd1, 0, 1, 0);
    checkOutput("single_X", X, 32'd1);
    checkOutput("single_x_valid", {31'b0, x_valid}, 32'd1);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("single_x_drained", {31'b0, x_valid}, 32'd0);
    checkOutput("single_x_count", {24'b0, x_count}, 32'd1);
    checkOutput("single_y_valid", {31'b0, y_valid}, 32'd0);

    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'd3, 0, 0, 0);
    applyStimulus(0, 1, 32'd4, 0, 0, 0);
    checkOutput("stall_X", X, 32'd3);
    applyStimulus(0, 1, 32'd4, 0, 1, 0);
    checkOutput("replace_X", X, 32'd4);
    checkOutput("replace_x_count", {24'b0, x_count}, 32'd1);

    applyStimulus(0, 1, 32'd5, 1, 0, 0);
    checkOutput("bypass_Y", Y, 32'd5);
    checkOutput("bypass_y_valid", {31'b0, y_valid}, 32'd1);
    checkOutput("bypass_X", X, 32'd4);

    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("dual_x_count", {24'b0, x_count}, 32'd2);
    checkOutput("dual_y_count", {24'b0, y_count}, 32'd1);

    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) applyStimulus(0, 1, 32'(i + 100), 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("wrap_y_count", {24'b0, y_count}, 32'd0);
    checkOutput("wrap_y_valid", {31'b0, y_valid}, 32'd0);

    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'hDEAD, 0, 0, 0);
    checkOutput("held_x_valid", {31'b0, x_valid}, 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("rst_x_valid", {31'b0, x_valid}, 32'd0);
    checkOutput("rst_X", X, 32'd0);
    checkOutput("rst_x_count", {24'b0, x_count}, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 99) == 0, 1'($urandom), $urandom,
                    1'($urandom), 1'($urandom), 1'($urandom));
    end

    monitorOn = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
